// File: rtl/operand_fetch.sv
// operand_fetch: decode-to-execute operand fetch stage absorbing the register file's registered read latency.
// Define OPFETCH_BYPASS_EN to forward late writebacks into fetched and held operands.
module operand_fetch #(
  parameter int NUM_ADDR_BITS = 6,
  parameter int REG_WIDTH = 32,
  parameter int OP_WIDTH = 6
) (
  input  logic clk,
  input  logic reset,
  input  logic in_valid,
  output logic in_ready,
  input  logic [OP_WIDTH-1:0] in_op,
  input  logic [NUM_ADDR_BITS-1:0] in_dst,
  input  logic [NUM_ADDR_BITS-1:0] in_srcA,
  input  logic [NUM_ADDR_BITS-1:0] in_srcB,
  input  logic [NUM_ADDR_BITS-1:0] in_srcC,
  output logic [NUM_ADDR_BITS-1:0] rdAddrA,
  output logic [NUM_ADDR_BITS-1:0] rdAddrB,
  output logic [NUM_ADDR_BITS-1:0] rdAddrC,
  input  logic [REG_WIDTH-1:0] rdDataA,
  input  logic [REG_WIDTH-1:0] rdDataB,
  input  logic [REG_WIDTH-1:0] rdDataC,
  input  logic wbEnable,
  input  logic [NUM_ADDR_BITS-1:0] wbAddr,
  input  logic [REG_WIDTH-1:0] wbData,
  output logic out_valid,
  input  logic out_ready,
  output logic [OP_WIDTH-1:0] out_op,
  output logic [NUM_ADDR_BITS-1:0] out_dst,
  output logic [REG_WIDTH-1:0] out_opA,
  output logic [REG_WIDTH-1:0] out_opB,
  output logic [REG_WIDTH-1:0] out_opC
);
  typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;
  state_t r_state;
  logic [OP_WIDTH-1:0] r_op;
  logic [NUM_ADDR_BITS-1:0] r_dst, r_src_a, r_src_b, r_src_c;
  logic w_accept;
  logic [2:0] w_fwd;
  assign in_ready = r_state == IDLE || (r_state == HOLD && out_ready);
  assign w_accept = in_valid && in_ready;
  assign rdAddrA = w_accept ? in_srcA : '0;
  assign rdAddrB = w_accept ? in_srcB : '0;
  assign rdAddrC = w_accept ? in_srcC : '0;
`ifdef OPFETCH_BYPASS_EN
  // register 0 is hardwired zero, so a writeback to it must never be forwarded
  assign w_fwd = {wbEnable && wbAddr == r_src_c && r_src_c != '0,
                  wbEnable && wbAddr == r_src_b && r_src_b != '0,
                  wbEnable && wbAddr == r_src_a && r_src_a != '0};
`else
  logic w_unused;
  assign w_fwd = '0;
  assign w_unused = ^{wbEnable, wbAddr};
`endif
  always_ff @(posedge clk)
    if (reset) begin
      r_state <= IDLE;
      r_op <= '0;
      r_dst <= '0;
      r_src_a <= '0;
      r_src_b <= '0;
      r_src_c <= '0;
      out_valid <= 1'b0;
      out_op <= '0;
      out_dst <= '0;
      out_opA <= '0;
      out_opB <= '0;
      out_opC <= '0;
    end else begin
      if (w_accept) begin
        r_op <= in_op;
        r_dst <= in_dst;
        r_src_a <= in_srcA;
        r_src_b <= in_srcB;
        r_src_c <= in_srcC;
      end
      case (r_state)
        IDLE: r_state <= w_accept ? FETCH : IDLE;
        FETCH: begin
          out_opA <= w_fwd[0] ? wbData : rdDataA;
          out_opB <= w_fwd[1] ? wbData : rdDataB;
          out_opC <= w_fwd[2] ? wbData : rdDataC;
          out_op <= r_op;
          out_dst <= r_dst;
          out_valid <= 1'b1;
          r_state <= HOLD;
        end
        HOLD:
          if (out_ready) begin
            out_valid <= 1'b0;
            r_state <= w_accept ? FETCH : IDLE;
          end else begin
            out_opA <= w_fwd[0] ? wbData : out_opA;
            out_opB <= w_fwd[1] ? wbData : out_opB;
            out_opC <= w_fwd[2] ? wbData : out_opC;
          end
        default: r_state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch: directed scenarios plus a randomized stream checked against a register-file-level model.
module tb_operand_fetch;
  logic clk = 1'b0;
  logic reset, in_valid, in_ready, wbEnable, out_valid, out_ready;
  logic [5:0] in_op, in_dst, in_srcA, in_srcB, in_srcC, rdAddrA, rdAddrB, rdAddrC, wbAddr, out_op, out_dst;
  logic [31:0] rdDataA, rdDataB, rdDataC, wbData, out_opA, out_opB, out_opC;
  logic [31:0] regs [64];
  int n_vec = 0;
  int n_err = 0;

  operand_fetch dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_dst(in_dst),
    .in_srcA(in_srcA), .in_srcB(in_srcB), .in_srcC(in_srcC), .rdAddrA(rdAddrA), .rdAddrB(rdAddrB), .rdAddrC(rdAddrC),
    .rdDataA(rdDataA), .rdDataB(rdDataB), .rdDataC(rdDataC), .wbEnable(wbEnable), .wbAddr(wbAddr), .wbData(wbData),
    .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op), .out_dst(out_dst),
    .out_opA(out_opA), .out_opB(out_opB), .out_opC(out_opC)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rf(input logic [5:0] a);
    return a == 6'd0 ? 32'd0 : regs[a];
  endfunction

  // register file model: writes on negedge, registered reads on posedge
  always @(negedge clk) if (wbEnable && wbAddr != 6'd0) regs[wbAddr] <= wbData;
  always @(posedge clk) begin
    rdDataA <= rf(rdAddrA);
    rdDataB <= rf(rdAddrB);
    rdDataC <= rf(rdAddrC);
  end

  function automatic logic [31:0] exp_val(input logic [5:0] s, input logic [31:0] snap);
`ifdef OPFETCH_BYPASS_EN
    return rf(s);
`else
    return snap;
`endif
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wb_write(input logic [5:0] a, input logic [31:0] d);
    wbEnable = 1'b1; wbAddr = a; wbData = d;
    tick;
    wbEnable = 1'b0;
  endtask

  task automatic issue(input logic [5:0] op, dst, a, b, c);
    int n = 0;
    in_valid = 1'b1; in_op = op; in_dst = dst; in_srcA = a; in_srcB = b; in_srcC = c;
    #1;
    while (in_ready !== 1'b1 && n < 20) begin tick; n++; end
    n_vec++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL issue_ready got %b want 1", in_ready); end
    n_vec++;
    if ({rdAddrA, rdAddrB, rdAddrC} !== {a, b, c})
      begin n_err++; $display("FAIL issue_rdaddr got %h/%h/%h want %h/%h/%h", rdAddrA, rdAddrB, rdAddrC, a, b, c); end
    tick;
    in_valid = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; wbEnable = 1'b0; wbAddr = '0; wbData = '0;
    in_op = '0; in_dst = '0; in_srcA = '0; in_srcB = '0; in_srcC = '0;
    tick; tick;
    reset = 1'b0;
    n_vec++;
    if ({out_valid, out_op, out_dst, out_opA, out_opB, out_opC} !== '0)
      begin n_err++; $display("FAIL reset_outputs got v=%b op=%h dst=%h %h/%h/%h want all 0", out_valid, out_op, out_dst, out_opA, out_opB, out_opC); end
    n_vec++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    n_vec++;
    if ({rdAddrA, rdAddrB, rdAddrC} !== '0) begin n_err++; $display("FAIL reset_rdaddr got %h/%h/%h want 0", rdAddrA, rdAddrB, rdAddrC); end
  endtask

  task automatic test_basic;
    wb_write(6'd5, 32'h11); wb_write(6'd6, 32'h22); wb_write(6'd7, 32'h33);
    out_ready = 1'b1;
    issue(6'h0A, 6'd9, 6'd5, 6'd6, 6'd7);
    n_vec++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL basic_latency got out_valid=%b want 0", out_valid); end
    n_vec++;
    if ({rdAddrA, rdAddrB, rdAddrC} !== '0) begin n_err++; $display("FAIL basic_idle_rdaddr got %h/%h/%h want 0", rdAddrA, rdAddrB, rdAddrC); end
    tick;
    n_vec++;
    if ({out_valid, out_op, out_dst, out_opA, out_opB, out_opC} !== {1'b1, 6'h0A, 6'd9, 32'h11, 32'h22, 32'h33})
      begin n_err++; $display("FAIL basic_out got v=%b op=%h dst=%h %h/%h/%h want 1 0a 09 11/22/33", out_valid, out_op, out_dst, out_opA, out_opB, out_opC); end
    tick;
    n_vec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("FAIL basic_release got v=%b rdy=%b want 0 1", out_valid, in_ready); end
  endtask

  task automatic test_zero_src;
    wb_write(6'd3, 32'h55);
    issue(6'h01, 6'd2, 6'd0, 6'd0, 6'd3);
    wbEnable = 1'b1; wbAddr = 6'd0; wbData = 32'hFF;
    tick;
    wbEnable = 1'b0;
    n_vec++;
    if ({out_valid, out_opA, out_opB, out_opC} !== {1'b1, 32'h0, 32'h0, 32'h55})
      begin n_err++; $display("FAIL zero_src got v=%b %h/%h/%h want 1 0/0/55", out_valid, out_opA, out_opB, out_opC); end
    tick;
  endtask

  task automatic test_bypass_fetch;
    logic [31:0] want;
`ifdef OPFETCH_BYPASS_EN
    want = 32'h200;
`else
    want = 32'h100;
`endif
    wb_write(6'd4, 32'h100);
    issue(6'h02, 6'd1, 6'd4, 6'd0, 6'd0);
    wbEnable = 1'b1; wbAddr = 6'd4; wbData = 32'h200;
    tick;
    wbEnable = 1'b0;
    n_vec++;
    if (out_valid !== 1'b1 || out_opA !== want) begin n_err++; $display("FAIL bypass_fetch got v=%b A=%h want 1 %h", out_valid, out_opA, want); end
    tick;
  endtask

  task automatic test_backpressure;
    logic [31:0] want_b;
`ifdef OPFETCH_BYPASS_EN
    want_b = 32'hABC;
`else
    want_b = 32'h777;
`endif
    wb_write(6'd8, 32'h777);
    out_ready = 1'b0;
    issue(6'h15, 6'h21, 6'd5, 6'd8, 6'd7);
    tick;
    for (int i = 0; i < 5; i++) begin
      n_vec++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0) begin n_err++; $display("FAIL bp_hold[%0d] got v=%b rdy=%b want 1 0", i, out_valid, in_ready); end
      if (i == 2) begin wbEnable = 1'b1; wbAddr = 6'd8; wbData = 32'hABC; end
      tick;
      wbEnable = 1'b0;
    end
    n_vec++;
    if ({out_valid, out_op, out_dst, out_opA, out_opB, out_opC} !== {1'b1, 6'h15, 6'h21, 32'h11, want_b, 32'h33})
      begin n_err++; $display("FAIL bp_operands got v=%b op=%h dst=%h %h/%h/%h want 1 15 21 11/%h/33", out_valid, out_op, out_dst, out_opA, out_opB, out_opC, want_b); end
    in_valid = 1'b1; in_op = 6'h16; in_dst = 6'h22; in_srcA = 6'd6; in_srcB = 6'd6; in_srcC = 6'd6; out_ready = 1'b1;
    #1;
    n_vec++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_same_cycle_accept got rdy=%b want 1", in_ready); end
    tick;
    in_valid = 1'b0;
    n_vec++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_gap got v=%b want 0", out_valid); end
    tick;
    n_vec++;
    if ({out_valid, out_op, out_opA, out_opB, out_opC} !== {1'b1, 6'h16, 32'h22, 32'h22, 32'h22})
      begin n_err++; $display("FAIL bp_next got v=%b op=%h %h/%h/%h want 1 16 22/22/22", out_valid, out_op, out_opA, out_opB, out_opC); end
    tick;
  endtask

  task automatic test_back_to_back;
    logic [5:0] s [4][3];
    logic [5:0] ops [4];
    logic acc;
    int idx = 0, got = 0, last = -1;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      ops[k] = 6'($urandom);
      for (int j = 0; j < 3; j++) s[k][j] = 6'($urandom_range(0, 9));
    end
    for (int cyc = 0; cyc < 30 && got < 4; cyc++) begin
      in_valid = idx < 4;
      if (idx < 4) begin in_op = ops[idx]; in_dst = 6'(idx); in_srcA = s[idx][0]; in_srcB = s[idx][1]; in_srcC = s[idx][2]; end
      #1;
      acc = in_valid && in_ready;
      tick;
      if (acc) idx++;
      if (out_valid === 1'b1) begin
        n_vec++;
        if (got >= 4 || {out_op, out_dst, out_opA, out_opB, out_opC} !== {ops[got], 6'(got), rf(s[got][0]), rf(s[got][1]), rf(s[got][2])})
          begin n_err++; $display("FAIL b2b_out[%0d] got op=%h dst=%h %h/%h/%h", got, out_op, out_dst, out_opA, out_opB, out_opC); end
        n_vec++;
        if (last >= 0 && cyc - last != 2) begin n_err++; $display("FAIL b2b_spacing got %0d cycles want 2", cyc - last); end
        last = cyc;
        got++;
      end
    end
    in_valid = 1'b0;
    n_vec++;
    if (got != 4) begin n_err++; $display("FAIL b2b_count got %0d want 4", got); end
  endtask

  task automatic test_random;
    logic m_fetch, m_valid, exp_ready, acc, leave;
    logic [5:0] p_op, p_dst, c_op, c_dst;
    logic [5:0] p_src [3];
    logic [5:0] c_src [3];
    logic [31:0] p_snap [3];
    logic [31:0] c_snap [3];
    reset = 1'b1; in_valid = 1'b0; wbEnable = 1'b0;
    tick;
    reset = 1'b0;
    m_fetch = 1'b0; m_valid = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      in_valid = $urandom_range(0, 3) != 0;
      in_op = 6'($urandom); in_dst = 6'($urandom);
      in_srcA = 6'($urandom_range(0, 7)); in_srcB = 6'($urandom_range(0, 7)); in_srcC = 6'($urandom_range(0, 7));
      out_ready = $urandom_range(0, 2) == 0;
      wbEnable = $urandom_range(0, 1) == 1; wbAddr = 6'($urandom_range(0, 7)); wbData = $urandom;
      #1;
      exp_ready = !m_fetch && (!m_valid || out_ready);
      n_vec++;
      if (in_ready !== exp_ready) begin n_err++; $display("FAIL rnd_in_ready[%0d] got %b want %b", cyc, in_ready, exp_ready); end
      acc = in_valid && exp_ready;
      n_vec++;
      if ({rdAddrA, rdAddrB, rdAddrC} !== (acc ? {in_srcA, in_srcB, in_srcC} : 18'd0))
        begin n_err++; $display("FAIL rnd_rdaddr[%0d] got %h/%h/%h", cyc, rdAddrA, rdAddrB, rdAddrC); end
      leave = m_valid && out_ready;
      if (acc) begin p_op = in_op; p_dst = in_dst; p_src[0] = in_srcA; p_src[1] = in_srcB; p_src[2] = in_srcC; end
      tick;
      if (m_fetch) begin
        m_valid = 1'b1; c_op = p_op; c_dst = p_dst; c_src = p_src; c_snap = p_snap;
      end else if (leave) m_valid = 1'b0;
      m_fetch = acc;
      if (acc) for (int j = 0; j < 3; j++) p_snap[j] = rf(p_src[j]);
      n_vec++;
      if (out_valid !== m_valid) begin n_err++; $display("FAIL rnd_out_valid[%0d] got %b want %b", cyc, out_valid, m_valid); end
      if (m_valid) begin
        n_vec++;
        if ({out_op, out_dst, out_opA, out_opB, out_opC} !== {c_op, c_dst, exp_val(c_src[0], c_snap[0]), exp_val(c_src[1], c_snap[1]), exp_val(c_src[2], c_snap[2])})
          begin n_err++; $display("FAIL rnd_out[%0d] got op=%h dst=%h %h/%h/%h want op=%h dst=%h %h/%h/%h", cyc, out_op, out_dst, out_opA, out_opB, out_opC,
            c_op, c_dst, exp_val(c_src[0], c_snap[0]), exp_val(c_src[1], c_snap[1]), exp_val(c_src[2], c_snap[2])); end
      end
    end
    in_valid = 1'b0; wbEnable = 1'b0;
  endtask

  task automatic test_reset_in_hold;
    out_ready = 1'b1;
    tick; tick;
    out_ready = 1'b0;
    issue(6'h07, 6'd3, 6'd5, 6'd6, 6'd7);
    tick;
    n_vec++;
    if (out_valid !== 1'b1) begin n_err++; $display("FAIL rst_hold_pre got v=%b want 1", out_valid); end
    reset = 1'b1; out_ready = 1'b1; in_valid = 1'b1; in_srcA = 6'd5;
    tick;
    reset = 1'b0; in_valid = 1'b0;
    n_vec++;
    if ({out_valid, out_op, out_dst, out_opA, out_opB, out_opC} !== '0 || in_ready !== 1'b1)
      begin n_err++; $display("FAIL rst_hold_clear got v=%b %h/%h/%h rdy=%b want 0 0/0/0 1", out_valid, out_opA, out_opB, out_opC, in_ready); end
    for (int i = 0; i < 3; i++) begin
      tick;
      n_vec++;
      if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_hold_ghost[%0d] got v=%b want 0", i, out_valid); end
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) regs[i] = '0;
    test_reset;
    test_basic;
    test_zero_src;
    test_bypass_fetch;
    test_backpressure;
    test_back_to_back;
    test_random;
    test_reset_in_hold;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/operand_fetch.md
# operand_fetch

Operand-fetch stage between instruction decode and the execute/MAC datapath of the CPU_NN core. Accepts one decoded instruction over a valid/ready handshake and drives up to three register-file read addresses. It absorbs the register file's one-cycle registered read latency, forwards late writebacks into fetched operands, and presents the instruction with operands A/B/C to execute over a second valid/ready handshake.

## Interface
- NUM_ADDR_BITS, 6, register address width; must match the register file.
- REG_WIDTH, 32, operand width.
- OP_WIDTH, 6, opcode field width, carried through untouched.

- clk  in  1  single clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  decode has an instruction.
- in_ready  out  1  stage accepts this cycle.
- in_op  in  OP_WIDTH  opcode.
- in_dst  in  NUM_ADDR_BITS  destination register.
- in_srcA / in_srcB / in_srcC  in  NUM_ADDR_BITS each  source registers; 0 means "operand is zero".
- rdAddrA / rdAddrB / rdAddrC  out  NUM_ADDR_BITS each  to register-file read ports.
- rdDataA / rdDataB / rdDataC  in  REG_WIDTH each  registered read data, valid the cycle after the address is sampled.
- wbEnable  in  1  writeback strobe, the same signal that drives the register-file write enable.
- wbAddr  in  NUM_ADDR_BITS  writeback address.
- wbData  in  REG_WIDTH  writeback data.
- out_valid  out  1  operands valid for execute.
- out_ready  in  1  execute accepts.
- out_op  out  OP_WIDTH  registered.
- out_dst  out  NUM_ADDR_BITS  registered.
- out_opA / out_opB / out_opC  out  REG_WIDTH each  registered operands.

## Operation
- States: IDLE, FETCH, HOLD.
- in_ready = (state==IDLE) | (state==HOLD & out_ready). It is combinational and does not depend on in_valid.
- accept = in_valid & in_ready.
- rdAddrX = accept ? in_srcX : 0. Address 0 returns zero from the register file.
- On accept, latch op, dst, srcA/B/C into internal registers, then go to FETCH.
- IDLE → FETCH on accept; otherwise stay in IDLE.
- FETCH lasts one cycle. Load out_opX with the forwarded value of rdDataX (see below), load out_op and out_dst, set out_valid=1, go to HOLD.
- HOLD with out_ready=0: stay, with outputs stable except forwarding updates.
- HOLD with out_ready=1: if accept, go to FETCH (out_valid drops for one cycle); else go to IDLE and clear out_valid.
- Forwarding, per operand X, when wbEnable & wbAddr==srcX & srcX!=0:
  - In FETCH, out_opX loads wbData instead of rdDataX.
  - In HOLD (not leaving), out_opX reloads wbData.
  - If several operands match, all of them are updated.
  - A source of 0 is never forwarded, even if wbAddr==0.
- A writeback in the accept cycle needs no forwarding: the register file writes on negedge before the posedge read.
- Throughput is one instruction per 2 cycles; accept-to-out_valid latency is 2 posedges.

## Timing
- Reset values: state=IDLE, out_valid=0, out_op=0, out_dst=0, out_opA/B/C=0, internal src/op/dst registers=0.
- in_ready=1 in the cycle immediately after reset deasserts.
- Reset during FETCH or HOLD discards the in-flight instruction; no partial out_valid is produced.
- Reset has priority over accept in the same cycle.
- out_valid, once high, stays high until a cycle with out_ready=1. Operands change only through forwarding.
- Execute handshake completes on the posedge where out_valid & out_ready.
- Upstream handshake completes on the posedge where in_valid & in_ready.
- Equal addresses across A/B/C are legal and read identical values.

## Configuration
- OPFETCH_BYPASS_EN defined: forwarding enabled in FETCH and HOLD as above.
- Undefined: no writeback comparison. out_opX = rdDataX at FETCH and is never updated in HOLD. wbEnable, wbAddr and wbData are unused, and decode must stall RAW hazards. Handshake and state behaviour are unchanged.

## Test plan
- Reset, then write reg5=0x11, reg6=0x22, reg7=0x33; issue srcA=5, srcB=6, srcC=7, op=0x0A, dst=9 with out_ready=1 → out_valid 2 posedges after accept with 0x11/0x22/0x33, out_op=0x0A, out_dst=9.
- srcA=0, srcB=0, srcC=3 with reg3=0x55, plus a writeback to addr 0 with 0xFF during FETCH → out_opA=out_opB=0, out_opC=0x55.
- Bypass in FETCH (macro defined): reg4=0x100, issue srcA=4, and in the FETCH cycle wbEnable=1, wbAddr=4, wbData=0x200 → out_opA=0x200. With the macro undefined → out_opA=0x100.
- Backpressure: out_ready=0 for 5 cycles after out_valid, with a wb to srcB (addr 8, 0xABC) in cycle 3 → out_valid held, out_opB=0xABC afterwards, other operands unchanged, in_ready=0 throughout. Raise out_ready with in_valid=1 → same-cycle accept, out_valid low for exactly 1 cycle.
- Back-to-back stream of 4 instructions with in_valid and out_ready held high → 4 outputs in order, one every 2 cycles, none dropped or duplicated.
- Assert reset in HOLD with out_valid=1 → next cycle out_valid=0, operands 0, in_ready=1, no output for the discarded instruction.
